// File: rtl/mic_frame_sched_if.sv
// Bus bundle between the I2S decoder, the HPS Avalon-MM master and mic_frame_sched.
// slave = scheduler side, master = decoder/HPS side.
interface mic_frame_sched_if;
  logic        frame_valid;
  logic [23:0] ch0;
  logic [23:0] ch1;
  logic [23:0] ch2;
  logic [23:0] ch3;
  logic        capture_en;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  frame_valid, ch0, ch1, ch2, ch3,
    input  chipselect, read, write, address, writedata,
    output capture_en, readdata, irq
  );

  modport master (
    output frame_valid, ch0, ch1, ch2, ch3,
    output chipselect, read, write, address, writedata,
    input  capture_en, readdata, irq
  );
endinterface

// File: rtl/mic_frame_sched.sv
// Mic capture gate, frame FIFO and HPS register map with level-based threshold irq.
// Optional MIC_FRAME_TIMESTAMP_EN stores a frame counter with each entry, readable at address 7.
module mic_frame_sched #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  mic_frame_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef MIC_FRAME_TIMESTAMP_EN
  localparam int ENTRY_W = 128;
`else
  localparam int ENTRY_W = 96;
`endif

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         ovf_q, ovf_d;
  logic               en_q, irq_en_q;
  logic [7:0]         thr_q;
  logic               irq_q, irq_d;
  logic [31:0]        readdata_q, rd_data;
  logic [ENTRY_W-1:0] entry_in, head_entry;
  logic [23:0]        head_ch [4];
  logic [31:0]        head_ts;
  logic [15:0]        level_ext;

  logic rd_strobe, wr_strobe, ctrl_wr, ack_wr;
  logic empty, full, pop, push_req, push, drop, flush;

  assign rd_strobe = bus.chipselect & bus.read;
  assign wr_strobe = bus.chipselect & bus.write;
  assign ctrl_wr   = wr_strobe & (bus.address == 3'd5);
  assign ack_wr    = wr_strobe & (bus.address == 3'd6) & bus.writedata[0];

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign pop      = rd_strobe & (bus.address == 3'd3) & ~empty;
  assign push_req = bus.frame_valid & (state_q == ST_RUN);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (ctrl_wr && bus.writedata[0]) state_d = ST_ARMED;
      ST_ARMED: begin
        if (ctrl_wr && !bus.writedata[0]) state_d = ST_DISABLED;
        else if (bus.frame_valid)         state_d = ST_RUN;
      end
      ST_RUN:      if (ctrl_wr && !bus.writedata[0]) state_d = ST_DISABLED;
      default:     state_d = ST_DISABLED;
    endcase
  end

  // Anything headed into (or sitting in) DISABLED keeps the FIFO empty.
  assign flush = (state_d == ST_DISABLED);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ack_wr)                     ovf_d = '0;
    else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  assign level_ext = {{(16-LVL_W){1'b0}}, level_q};
  assign irq_d     = irq_en_q & (thr_q != 8'd0) & (level_ext >= {8'd0, thr_q});

`ifdef MIC_FRAME_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (state_q == ST_DISABLED && state_d == ST_ARMED)
      ts_d = '0;
    else if (bus.frame_valid && state_q != ST_DISABLED)
      ts_d = ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign entry_in = {ts_q, bus.ch3, bus.ch2, bus.ch1, bus.ch0};
  assign head_ts  = empty ? 32'd0 : head_entry[127:96];
`else
  assign entry_in = {bus.ch3, bus.ch2, bus.ch1, bus.ch0};
  assign head_ts  = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= entry_in;
  end

  assign head_entry = mem[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_head_ch
      assign head_ch[gi] = empty ? 24'd0 : head_entry[24*gi +: 24];
    end
  endgenerate

  always_comb begin
    rd_data = 32'd0;
    case (bus.address)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = {8'd0, head_ch[bus.address[1:0]]};
      3'd4:    rd_data = {ovf_q, 6'd0, state_q, level_ext};
      3'd5:    rd_data = {16'd0, thr_q, 6'd0, irq_en_q, en_q};
      3'd7:    rd_data = head_ts;
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_DISABLED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      thr_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      if (ctrl_wr) begin
        en_q     <= bus.writedata[0];
        irq_en_q <= bus.writedata[1];
        thr_q    <= bus.writedata[15:8];
      end
      if (rd_strobe) readdata_q <= rd_data;
    end
  end

  logic unused_wd;
  assign unused_wd = ^{bus.writedata[31:16], bus.writedata[7:2]};

  assign bus.capture_en = (state_q != ST_DISABLED);
  assign bus.readdata   = readdata_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_mic_frame_sched.sv
// Self-checking bench for mic_frame_sched: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the FIFO and register map.
module tb_mic_frame_sched;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  mic_frame_sched_if bus();
  mic_frame_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] ts;
    logic [23:0] c3;
    logic [23:0] c2;
    logic [23:0] c1;
    logic [23:0] c0;
  } frame_t;

  frame_t      q[$];
  int          m_state;   // 0 disabled, 1 armed, 2 run
  int          m_ovf;
  int          m_thr;
  bit          m_en;
  bit          m_irq_en;
  logic [31:0] m_ts;
  logic [31:0] m_rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    frame_t      h;
    logic [31:0] r;
    h = (q.size() > 0) ? q[0] : '0;
    r = 32'd0;
    case (a)
      3'd0: r = {8'd0, h.c0};
      3'd1: r = {8'd0, h.c1};
      3'd2: r = {8'd0, h.c2};
      3'd3: r = {8'd0, h.c3};
      3'd4: r = {8'(m_ovf), 6'd0, 2'(m_state), 16'(q.size())};
      3'd5: r = {16'd0, 8'(m_thr), 6'd0, m_irq_en, m_en};
`ifdef MIC_FRAME_TIMESTAMP_EN
      3'd7: r = h.ts;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0; m_ovf = 0; m_thr = 0; m_en = 0; m_irq_en = 0;
    m_ts = 0; m_rd = 0;
  endtask

  task automatic bus_idle();
    bus.frame_valid = 0;
    bus.ch0 = 0; bus.ch1 = 0; bus.ch2 = 0; bus.ch3 = 0;
    bus.chipselect = 0; bus.read = 0; bus.write = 0;
    bus.address = 0; bus.writedata = 0;
  endtask

  // One clock: sample inputs, advance the model across the edge, compare outputs.
  task automatic tick();
    bit          rd_s, wr_s, fv, pop;
    logic [2:0]  a;
    logic [31:0] wd;
    logic        exp_irq;
    int          nxt;
    frame_t      f;
    rd_s = bus.chipselect && bus.read;
    wr_s = bus.chipselect && bus.write;
    fv   = bus.frame_valid;
    a    = bus.address;
    wd   = bus.writedata;
    f.ts = m_ts; f.c0 = bus.ch0; f.c1 = bus.ch1; f.c2 = bus.ch2; f.c3 = bus.ch3;
    exp_irq = !reset && m_irq_en && m_thr != 0 && q.size() >= m_thr;
    pop = rd_s && a == 3'd3 && q.size() > 0;
    if (rd_s) m_rd = model_read(a);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (fv && m_state == 2) begin
        if (q.size() < DEPTH) q.push_back(f);
        else if (m_ovf < 255) m_ovf++;
      end
      if (fv && m_state != 0) m_ts++;
      if (wr_s && a == 3'd6 && wd[0]) m_ovf = 0;
      nxt = m_state;
      if (wr_s && a == 3'd5) begin
        if (wd[0] && m_state == 0) begin nxt = 1; m_ts = 0; end
        else if (!wd[0]) nxt = 0;
        m_en = wd[0]; m_irq_en = wd[1]; m_thr = int'(wd[15:8]);
      end
      if (m_state == 1 && fv && nxt == 1) nxt = 2;
      m_state = nxt;
      if (m_state == 0) q.delete();
    end
    #1;
    check("readdata", bus.readdata, m_rd);
    check("irq", {31'd0, bus.irq}, {31'd0, exp_irq});
    check("capture_en", {31'd0, bus.capture_en}, {31'd0, (m_state != 0)});
    if (rd_s) $display("rd a=%0d data=0x%08h level=%0d", a, bus.readdata, q.size());
    if (wr_s) $display("wr a=%0d data=0x%08h state=%0d", a, wd, m_state);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    bus_idle();
    bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
    tick();
    bus_idle();
  endtask

  task automatic do_read(input logic [2:0] a);
    bus_idle();
    bus.chipselect = 1; bus.read = 1; bus.address = a;
    tick();
    bus_idle();
  endtask

  task automatic send_frame(input logic [23:0] c0, input logic [23:0] c1,
                            input logic [23:0] c2, input logic [23:0] c3);
    bus_idle();
    bus.frame_valid = 1; bus.ch0 = c0; bus.ch1 = c1; bus.ch2 = c2; bus.ch3 = c3;
    tick();
    bus_idle();
  endtask

  task automatic send_rand_frame();
    send_frame(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    model_reset();
    bus_idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_cap", {31'd0, bus.capture_en}, 32'd0);
    do_read(3'd4);
    check("rst_status", bus.readdata, 32'd0);

    // Arm, first frame discarded, second frame buffered and drained.
    do_write(3'd5, 32'h0000_0001);
    check("arm_cap", {31'd0, bus.capture_en}, 32'd1);
    send_frame(24'hA0A0A0, 24'hA1A1A1, 24'hA2A2A2, 24'hA3A3A3);
    send_frame(24'd1, 24'd2, 24'd3, 24'd4);
    do_read(3'd4);
    check("first_status", bus.readdata, 32'h0002_0001);
    for (int k = 0; k < 4; k++) begin
      do_read(3'(k));
      check("first_chan", bus.readdata, 32'(k + 1));
    end
    do_read(3'd4);
    check("first_drained", bus.readdata, 32'h0002_0000);
    do_read(3'd0);
    check("empty_read", bus.readdata, 32'd0);

    // Overflow: 18 frames into 16 slots, then ACK.
    for (int k = 0; k < 18; k++) send_rand_frame();
    do_read(3'd4);
    check("ovf_status", bus.readdata, 32'h0202_0010);
    do_write(3'd6, 32'd1);
    do_read(3'd4);
    check("ack_status", bus.readdata, 32'h0002_0010);

    // Full FIFO: pop and push in the same cycle.
    bus_idle();
    bus.frame_valid = 1; bus.ch0 = 24'h111111; bus.ch1 = 24'h222222;
    bus.ch2 = 24'h333333; bus.ch3 = 24'h444444;
    bus.chipselect = 1; bus.read = 1; bus.address = 3'd3;
    tick();
    bus_idle();
    do_read(3'd4);
    check("full_pushpop", bus.readdata, 32'h0002_0010);
    for (int k = 0; k < 16; k++) begin
      do_read(3'd0);
      do_read(3'd3);
    end
    check("tail_frame_ch3", bus.readdata, 32'h0044_4444);

    // Threshold irq.
    do_write(3'd5, 32'h0000_0000);
    do_write(3'd5, 32'h0000_0403);
    send_rand_frame();
    for (int k = 0; k < 4; k++) send_rand_frame();
    check("irq_not_yet", {31'd0, bus.irq}, 32'd0);
    tick();
    check("irq_rise", {31'd0, bus.irq}, 32'd1);
    do_read(3'd3);
    check("irq_hold", {31'd0, bus.irq}, 32'd1);
    tick();
    check("irq_fall", {31'd0, bus.irq}, 32'd0);

    // Disable with level 5: flush, ignore frames.
    send_rand_frame(); send_rand_frame();
    do_write(3'd5, 32'h0000_0000);
    check("dis_cap", {31'd0, bus.capture_en}, 32'd0);
    do_read(3'd4);
    check("dis_status", bus.readdata, 32'h0000_0000);
    send_rand_frame();
    do_read(3'd4);
    check("dis_ignore", bus.readdata, 32'h0000_0000);

`ifdef MIC_FRAME_TIMESTAMP_EN
    do_write(3'd5, 32'h0000_0001);
    for (int k = 0; k < 4; k++) send_rand_frame();
    for (int k = 1; k <= 3; k++) begin
      do_read(3'd7);
      check("ts_head", bus.readdata, 32'(k));
      do_read(3'd3);
    end
    do_read(3'd7);
    check("ts_empty", bus.readdata, 32'd0);
    do_write(3'd5, 32'h0000_0000);
`else
    do_read(3'd7);
    check("addr7_zero", bus.readdata, 32'd0);
`endif

    // Randomized traffic with a mid-run reset.
    do_write(3'd5, 32'h0000_0301);
    for (int i = 0; i < 1200; i++) begin
      bus_idle();
      bus.frame_valid = ($urandom_range(0, 2) == 0);
      bus.ch0 = 24'($urandom); bus.ch1 = 24'($urandom);
      bus.ch2 = 24'($urandom); bus.ch3 = 24'($urandom);
      bus.chipselect = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        bus.read = 1;
        bus.address = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom_range(0, 7));
      end else if (r < 50) begin
        bus.write = 1; bus.address = 3'd6; bus.writedata = $urandom;
      end else if (r < 54) begin
        bus.write = 1; bus.address = 3'd5;
        bus.writedata = {16'($urandom), 8'($urandom_range(0, 20)), 6'($urandom),
                         1'($urandom), ($urandom_range(0, 9) != 0)};
      end else if (r < 56) begin
        bus.write = 1; bus.address = 3'($urandom_range(0, 4)); bus.writedata = $urandom;
      end
      reset = (i == 600);
      tick();
      if (i == 600) begin
        reset = 0;
        bus_idle();
        do_read(3'd4);
        check("midrst_status", bus.readdata, 32'd0);
        do_write(3'd5, 32'h0000_0201);
      end
    end
    reset = 0;
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mic_frame_sched.md
Name: mic_frame_sched

Overview:
- Capture controller and scheduler between the I2S microphone decoder and the HPS Avalon-MM slave port.
- Gates capture, and accepts one 4-channel 24-bit frame per frame_valid pulse (left/right of mic sets 1 and 2).
- Buffers frames in a FIFO and raises a level-based interrupt when a programmable threshold is reached.
- Lets the HPS drain frames through a register map.

Parameters:
- DEPTH, 16: FIFO depth in frames; power of two, 2..256.
- LVL_W, $clog2(DEPTH)+1: width of the level counter.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- frame_valid  in  1  one-clk pulse; a complete frame is present on ch0..ch3 (already synchronised to clk)
- ch0  in  24  left, mic set 1
- ch1  in  24  right, mic set 1
- ch2  in  24  left, mic set 2
- ch3  in  24  right, mic set 2
- capture_en  out  1  enable to the decoder
- chipselect  in  1  Avalon select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  3  register index
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt to HPS

Behaviour:
- Reset values: capture_en=0, irq=0, readdata=0, FIFO empty (level=0), ovf_cnt=0, ctrl=0, state DISABLED.
- Single clock domain; all updates on posedge clk.

Register map (a read returns data on the cycle after the strobe, i.e. readdata is registered):
- 0..2: {8'b0, ch0..ch2 of head frame}. Non-destructive.
- 3: {8'b0, ch3 of head frame}. Pops the head frame.
- 4 STATUS (RO): {ovf_cnt[7:0] at 31:24, state[1:0] at 17:16, zero-padded level at 15:0}.
- 5 CTRL (RW): bit0 enable, bit1 irq_en, bits 15:8 threshold.
- 6 ACK (WO): writing bit0=1 clears ovf_cnt. Reads return 0.
- 7: reserved; reads 0.
- Read of 0..3 with the FIFO empty: returns 0, no pop, no error.

State machine:
- DISABLED: capture_en=0, frames ignored, FIFO held flushed (level forced to 0 each cycle). Goes to ARMED on a CTRL write with enable=1.
- ARMED: capture_en=1. The first frame_valid is discarded, because it may be a partial frame after enable. Goes to RUN on that pulse.
- RUN: capture_en=1; each frame_valid pushes the frame.
- Leaving ARMED or RUN: a CTRL write with enable=0 returns to DISABLED on the next clk and flushes the FIFO. ovf_cnt is retained.
- The decoder sees capture_en deassert on the next clk.

FIFO:
- 96 bits wide per entry; circular read/write pointers wrap modulo DEPTH.
- Push while full: frame dropped, pointers unchanged, ovf_cnt increments, saturating at 255.
- Push and pop in the same cycle:
  - both take effect and level is unchanged;
  - when full, the push is accepted (the pop frees the slot);
  - when empty, the push lands and the pop is ignored.
- frame_valid in DISABLED, or the discarded ARMED pulse: never counted as overflow.

IRQ:
- irq registered = irq_en & (threshold!=0) & (level >= threshold), recomputed every cycle.
- Deasserts one clk after the level falls below threshold (HPS drains by reading addr 3).
- Threshold > DEPTH: irq never asserts.

Reset mid-operation: returns everything to reset values on the next edge, and drops any buffered frames.

Optional Feature:
- Macro: MIC_FRAME_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running frame counter increments on every frame_valid seen in ARMED or RUN, including dropped frames. It clears on reset and on entry to ARMED.
  - Its value is stored alongside each pushed frame (FIFO width 128).
  - Address 7 returns the head frame's timestamp, non-destructive, 0 when empty.
- Undefined: no counter, FIFO width 96, address 7 reads 0.

Test Plan:
- Reset, write CTRL=0x0000_0001, pulse frame_valid twice with frames A then B (ch0=0x000001..ch3=0x000004 for B) -> A discarded, level=1; reads of addr 0..3 return 0x00000001..0x00000004; level=0 after the addr 3 read.
- DEPTH=16, RUN, 18 frames with no reads -> level=16, STATUS[31:24]=2; write ACK=1 -> ovf_cnt=0, level stays 16.
- CTRL=0x0000_0403 (threshold 4, irq_en, enable), push 4 frames after the arm frame -> irq rises the cycle after the 4th push; one addr 3 read -> irq falls the following cycle.
- FIFO full, and an addr 3 read in the same cycle as frame_valid -> level stays 16, no overflow increment, new frame appears at the tail.
- RUN with level=5, write CTRL=0 -> next cycle capture_en=0, state DISABLED, level=0; further frame_valid ignored; ovf_cnt unchanged.
- MIC_FRAME_TIMESTAMP_EN defined: arm, then push 3 frames -> addr 7 returns 1, 2, 3 as successive head frames are popped; empty FIFO -> addr 7 returns 0.
